bird_motion_ctrl: RTL

Parametrised bird controller for the flappy-bird datapath. It replaces the flag-driven raise/fall FSM with an integrated vertical-physics engine: signed velocity, gravity, flap impulse, and ceiling/floor handling. Each frame it sequences an erase/move/draw cycle through a request/done handshake with the VGA plotter. It sits between the keyboard/collision logic and the bird plotter.

---
 rtl/bird_motion_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/bird_motion_ctrl.sv
// -----------------------------------------------------------------------------
// bird_motion_ctrl
//
// Bird controller for the flappy-bird datapath. Holds the bird's vertical
// physics (signed velocity, gravity, flap impulse, ceiling/floor clamp) and
// sequences one erase -> move -> draw cycle per video frame through a
// request/done handshake with the bird plotter.
//
// Optional feature macro: BIRD_VEL_CAP_EN
//   defined   : downward velocity after the gravity add is clamped to V_MAX
//   undefined : only the signed V_W range limits the velocity
//
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   frame_tick in   one-cycle pulse per video frame
//   press_key  in   flap/start key (level, rising edge used)
//   touched    in   pipe collision (level)
//   draw_done  in   plotter finished the current request
//   draw_req   out  plot request, held until draw_done
//   erase      out  1 = plot background at bird_y, 0 = plot bird
//   bird_y     out  current top row of the bird
//   alive      out  high in WAIT/ERASE/MOVE/DRAW
//   state_out  out  encoded state (debug/HEX)
//   overrun    out  sticky: frame_tick arrived outside S_WAIT
// -----------------------------------------------------------------------------
module bird_motion_ctrl #(
  parameter int Y_W     = 7,
  parameter int V_W     = 5,
  parameter int Y_MAX   = 120,
  parameter int BIRD_H  = 4,
  parameter int Y_START = 56,
  parameter int GRAVITY = 1,
  parameter int FLAP_V  = 4,
  parameter int V_MAX   = 6
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic           press_key,
  input  logic           touched,
  input  logic           draw_done,
  output logic           draw_req,
  output logic           erase,
  output logic [Y_W-1:0] bird_y,
  output logic           alive,
  output logic [2:0]     state_out,
  output logic           overrun
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_WAIT  = 3'd1,
    S_ERASE = 3'd2,
    S_MOVE  = 3'd3,
    S_DRAW  = 3'd4,
    S_DEAD  = 3'd5
  } state_t;

  localparam int Y_FLOOR = Y_MAX - BIRD_H;

`ifdef BIRD_VEL_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  // Velocity limits, kept one bit wider than the register so the gravity
  // add can be compared before it wraps.
  localparam logic signed [V_W:0] VW_HI  = (V_W+1)'((2 ** (V_W-1)) - 1);
  localparam logic signed [V_W:0] VW_LO  = (V_W+1)'(-(2 ** (V_W-1)));
  localparam logic signed [V_W:0] VCAP   = (V_W+1)'(V_MAX);
  localparam logic signed [V_W:0] CAP_HI = (CAP_EN && (VCAP < VW_HI)) ? VCAP : VW_HI;

  localparam logic signed [V_W-1:0] FLAP_NEG  = V_W'(-FLAP_V);
  localparam logic signed [V_W:0]   GRAV_S    = (V_W+1)'(GRAVITY);
  localparam logic signed [Y_W+1:0] Y_FLOOR_S = (Y_W+2)'(Y_FLOOR);
  localparam logic [Y_W-1:0]        Y_START_U = Y_W'(Y_START);
  localparam logic [Y_W-1:0]        Y_FLOOR_U = Y_W'(Y_FLOOR);

  // Clamp a widened velocity back into the register range (and to the
  // terminal velocity when the cap is enabled).
  function automatic logic signed [V_W-1:0] sat_vel(input logic signed [V_W:0] v);
    logic signed [V_W:0] r;
    r = v;
    if (v > CAP_HI)
      r = CAP_HI;
    else if (v < VW_LO)
      r = VW_LO;
    return $signed(r[V_W-1:0]);
  endfunction

  state_t                r_state;
  logic signed [V_W-1:0] r_vel;
  logic [Y_W-1:0]        r_bird_y;
  logic                  r_flap_pend;
  logic                  r_hit;
  logic                  r_key_q;
  logic                  r_draw_req;
  logic                  r_erase;
  logic                  r_overrun;

  logic                  w_rise;
  logic                  w_active;
  logic                  w_hit_now;
  logic signed [V_W:0]   w_vel_sum;
  logic signed [V_W-1:0] w_vel_grav;
  logic signed [V_W-1:0] w_vel_n;
  logic signed [Y_W+1:0] w_y_n;

  assign w_rise   = press_key & ~r_key_q;
  assign w_active = (r_state == S_WAIT) || (r_state == S_ERASE) ||
                    (r_state == S_MOVE) || (r_state == S_DRAW);
  // A collision this cycle counts immediately, so touched and flap in the
  // same MOVE cycle freezes the bird.
  assign w_hit_now = r_hit | (touched & w_active);

  assign w_vel_sum  = {r_vel[V_W-1], r_vel} + GRAV_S;
  assign w_vel_grav = sat_vel(w_vel_sum);
  assign w_vel_n    = r_flap_pend ? FLAP_NEG : w_vel_grav;
  // Two guard bits: one for the unsigned-to-signed step, one for overflow.
  assign w_y_n      = $signed({2'b00, r_bird_y}) +
                      $signed({{(Y_W+2-V_W){w_vel_n[V_W-1]}}, w_vel_n});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_START;
      r_bird_y    <= Y_START_U;
      r_vel       <= '0;
      r_draw_req  <= 1'b0;
      r_erase     <= 1'b0;
      r_overrun   <= 1'b0;
      r_flap_pend <= 1'b0;
      r_hit       <= 1'b0;
      r_key_q     <= 1'b0;
    end else begin
      r_key_q <= press_key;

      // A tick outside WAIT is dropped; only the sticky flag remembers it.
      if (frame_tick && (r_state != S_WAIT))
        r_overrun <= 1'b1;

      if (w_active) begin
        r_hit <= w_hit_now;
        if (w_rise)
          r_flap_pend <= 1'b1;
      end

      case (r_state)
        S_START: begin
          r_bird_y    <= Y_START_U;
          r_vel       <= '0;
          r_hit       <= 1'b0;
          r_flap_pend <= 1'b0;
          r_draw_req  <= 1'b0;
          r_erase     <= 1'b0;
          if (w_rise) begin
            r_state    <= S_DRAW;
            r_draw_req <= 1'b1;
            r_erase    <= 1'b0;
          end
        end

        S_WAIT: begin
          if (frame_tick) begin
            r_state    <= S_ERASE;
            r_draw_req <= 1'b1;
            r_erase    <= 1'b1;
          end
        end

        S_ERASE: begin
          if (draw_done) begin
            r_state    <= S_MOVE;
            r_draw_req <= 1'b0;
          end
        end

        S_MOVE: begin
          r_flap_pend <= 1'b0;
          if (!w_hit_now) begin
            if (w_y_n < 0) begin
              r_bird_y <= '0;
              r_vel    <= '0;
            end else if (w_y_n >= Y_FLOOR_S) begin
              r_bird_y <= Y_FLOOR_U;
              r_vel    <= '0;
              r_hit    <= 1'b1;
            end else begin
              r_bird_y <= w_y_n[Y_W-1:0];
              r_vel    <= w_vel_n;
            end
          end
          r_state    <= S_DRAW;
          r_draw_req <= 1'b1;
          r_erase    <= 1'b0;
        end

        S_DRAW: begin
          if (draw_done) begin
            r_draw_req <= 1'b0;
            r_state    <= w_hit_now ? S_DEAD : S_WAIT;
          end
        end

        S_DEAD: begin
          // Bird remains on screen; a fresh key press restarts the game.
          if (w_rise) begin
            r_state  <= S_START;
            r_bird_y <= Y_START_U;
            r_vel    <= '0;
          end
        end

        default: begin
          r_state    <= S_START;
          r_draw_req <= 1'b0;
          r_erase    <= 1'b0;
        end
      endcase
    end
  end

  assign draw_req  = r_draw_req;
  assign erase     = r_erase;
  assign bird_y    = r_bird_y;
  assign alive     = w_active;
  assign state_out = r_state;
  assign overrun   = r_overrun;

endmodule
